// File: rtl/ark_col_sequencer.sv
// AddRoundKey sequencer: feeds one 32-bit state column and key word per cycle
// into the shared column-XOR datapath, then captures and returns the 128-bit result.
module ark_col_sequencer #(
    parameter int COL_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] key_in,
    output logic [7:0]   xm_in_1,
    output logic [7:0]   xm_in_2,
    output logic [7:0]   xm_in_3,
    output logic [7:0]   xm_in_4,
    output logic [31:0]  xm_key,
    output logic [2:0]   xm_i,
    input  logic [127:0] xm_result,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [127:0] result_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(COL_LAT - 1);

    state_t        state;
    state_t        next_state;
    logic [1:0]    col;
    logic [2:0]    wait_cnt;
    logic [127:0]  state_q;
    logic [127:0]  key_q;

    logic          accept;
    logic          issue_step;
    logic          issue_last;
    logic          wait_done;
    logic          capture;
    logic          issue_load;
    logic [1:0]    issue_col;
    logic [127:0]  src_state;
    logic [127:0]  src_key;
    logic [31:0]   issue_word;
    logic [31:0]   issue_kw;
    logic          start_ready_d;
    logic          busy_d;
    logic          result_valid_d;

    // Column 0 is the most significant word of both state and key.
    function automatic logic [31:0] col_word(input logic [127:0] v, input logic [1:0] k);
        logic [31:0] w;
        case (k)
            2'd0:    w = v[127:96];
            2'd1:    w = v[95:64];
            2'd2:    w = v[63:32];
            default: w = v[31:0];
        endcase
        return w;
    endfunction

    assign accept     = (state == IDLE) && start_valid && start_ready;
    assign issue_step = (state == ISSUE) && (col != 2'd3);
    assign issue_last = (state == ISSUE) && (col == 2'd3);
    assign wait_done  = (wait_cnt == WAIT_LAST);
    assign capture    = (state == WAIT) && wait_done;

    // NOTE: state and datapath registers use non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (accept)                        next_state = ISSUE;
            ISSUE: if (issue_last)                    next_state = WAIT;
            WAIT:  if (wait_done)                     next_state = DONE;
            DONE:  if (result_valid && result_ready)  next_state = IDLE;
            default:                                  next_state = IDLE;
        endcase
    end

    // Outputs are registered, so this computes the values loaded at the next edge.
    always_comb begin
        start_ready_d  = (next_state == IDLE);
        busy_d         = (next_state != IDLE);
        result_valid_d = (next_state == DONE);
        issue_load     = accept || issue_step;
        issue_col      = accept ? 2'd0 : col + 2'd1;
        src_state      = accept ? state_in : state_q;
        src_key        = accept ? key_in : key_q;
        issue_word     = col_word(src_state, issue_col);
        issue_kw       = col_word(src_key, issue_col);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col          <= 2'd0;
            wait_cnt     <= 3'd0;
            state_q      <= '0;
            key_q        <= '0;
            xm_in_1      <= 8'h00;
            xm_in_2      <= 8'h00;
            xm_in_3      <= 8'h00;
            xm_in_4      <= 8'h00;
            xm_key       <= 32'h0;
            xm_i         <= 3'd0;
            result_out   <= '0;
            start_ready  <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            start_ready  <= start_ready_d;
            busy         <= busy_d;
            result_valid <= result_valid_d;

            if (accept) begin
                state_q <= state_in;
                key_q   <= key_in;
            end

            if (issue_load) begin
                col     <= issue_col;
                xm_i    <= {1'b0, issue_col};
                xm_in_1 <= issue_word[31:24];
                xm_in_2 <= issue_word[23:16];
                xm_in_3 <= issue_word[15:8];
                xm_in_4 <= issue_word[7:0];
                xm_key  <= issue_kw;
            end

            // xm_* outside this branch keep column 3, so the datapath never sees xm_i >= 4.
            if (issue_last) begin
                wait_cnt <= 3'd0;
            end else if ((state == WAIT) && !wait_done) begin
                wait_cnt <= wait_cnt + 3'd1;
            end

            if (capture) begin
                result_out <= xm_result;
            end
        end
    end

endmodule

// File: tb/tb_ark_col_sequencer.sv
// Bench for ark_col_sequencer: two builds (COL_LAT 1 and 3), each paired with a
// behavioural column-XOR datapath; results are checked against state ^ key.
module tb_ark_col_sequencer;

    logic         clk;
    logic         reset;
    logic         start_valid;
    logic         result_ready;
    logic [127:0] state_in;
    logic [127:0] key_in;
    logic         sel;

    int total;
    int bad;

    logic         sv1, sv3, rr1, rr3;
    logic         start_ready1, start_ready3, result_valid1, result_valid3, busy1, busy3;
    logic [7:0]   a1, b1, c1, d1, a3, b3, c3, d3;
    logic [31:0]  key1, key3;
    logic [2:0]   i1, i3;
    logic [127:0] xr1, xr3, ro1, ro3;

    assign sv1 = start_valid & ~sel;
    assign sv3 = start_valid & sel;
    assign rr1 = result_ready & ~sel;
    assign rr3 = result_ready & sel;

    ark_col_sequencer #(.COL_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start_valid(sv1), .start_ready(start_ready1),
        .state_in(state_in), .key_in(key_in),
        .xm_in_1(a1), .xm_in_2(b1), .xm_in_3(c1), .xm_in_4(d1),
        .xm_key(key1), .xm_i(i1), .xm_result(xr1),
        .result_valid(result_valid1), .result_ready(rr1), .result_out(ro1), .busy(busy1)
    );

    ark_col_sequencer #(.COL_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .start_valid(sv3), .start_ready(start_ready3),
        .state_in(state_in), .key_in(key_in),
        .xm_in_1(a3), .xm_in_2(b3), .xm_in_3(c3), .xm_in_4(d3),
        .xm_key(key3), .xm_i(i3), .xm_result(xr3),
        .result_valid(result_valid3), .result_ready(rr3), .result_out(ro3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath models: column write of bytes ^ key, out-of-range index clears all.
    logic [127:0] dp1, dp3, dp3_p1, dp3_p2;
    always @(posedge clk) begin
        if (i1 < 3'd4) dp1[127 - 32*i1 -: 32] <= {a1, b1, c1, d1} ^ key1;
        else           dp1 <= '0;
        if (i3 < 3'd4) dp3[127 - 32*i3 -: 32] <= {a3, b3, c3, d3} ^ key3;
        else           dp3 <= '0;
        dp3_p1 <= dp3;
        dp3_p2 <= dp3_p1;
    end
    assign xr1 = dp1;
    assign xr3 = dp3_p2;

    logic         o_sr, o_rv, o_busy;
    logic [2:0]   o_i;
    logic [31:0]  o_bytes, o_key;
    logic [127:0] o_out;
    always_comb begin
        o_sr    = sel ? start_ready3 : start_ready1;
        o_rv    = sel ? result_valid3 : result_valid1;
        o_busy  = sel ? busy3 : busy1;
        o_i     = sel ? i3 : i1;
        o_bytes = sel ? {a3, b3, c3, d3} : {a1, b1, c1, d1};
        o_key   = sel ? key3 : key1;
        o_out   = sel ? ro3 : ro1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wd(input logic [127:0] v, input int k);
        return v[127 - 32*k -: 32];
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One job from IDLE: checks issue stream, latency, backpressure and handshake.
    task automatic run_job(input logic [127:0] s, input logic [127:0] k, input int lat,
                           input int hold, input bit intrude);
        logic [127:0] exp;
        exp = s ^ k;
        check("sr_idle", 128'(o_sr), 128'(1'b1));
        state_in = s; key_in = k; start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        state_in = rnd128(); key_in = rnd128();
        for (int c = 0; c < 4; c++) begin
            check("issue_i", 128'(o_i), 128'(c));
            check("issue_bytes", 128'(o_bytes), 128'(wd(s, c)));
            check("issue_key", 128'(o_key), 128'(wd(k, c)));
            check("issue_busy", 128'({o_busy, o_sr, o_rv}), 128'(3'b100));
            if (intrude && c == 1) begin
                start_valid = 1'b1; state_in = rnd128(); key_in = rnd128();
            end
            if (intrude && c == 2) start_valid = 1'b0;
            if (c < 3) @(negedge clk);
        end
        for (int w = 0; w < lat; w++) begin
            @(negedge clk);
            check("wait_rv", 128'(o_rv), 128'(1'b0));
            check("wait_i", 128'(o_i), 128'(3));
        end
        @(negedge clk);
        check("done_rv", 128'(o_rv), 128'(1'b1));
        check("done_out", o_out, exp);
        check("done_sr", 128'(o_sr), 128'(1'b0));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("bp_hold", 128'({o_rv, o_sr, o_i}), 128'({1'b1, 1'b0, 3'd3}));
            check("bp_out", o_out, exp);
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check("post_hs", 128'({o_rv, o_sr, o_busy}), 128'(3'b010));
        check("post_out", o_out, exp);
    endtask

    localparam logic [127:0] FIPS_S = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_R = 128'h00102030405060708090a0b0c0d0e0f0;

    initial begin
        logic [127:0] s;
        total = 0; bad = 0; sel = 1'b0;
        reset = 1'b0; start_valid = 1'b0; result_ready = 1'b0;
        state_in = '0; key_in = '0;
        repeat (3) @(negedge clk);
        check("rst_flags", 128'({o_sr, o_rv, o_busy}), 128'(3'b000));
        check("rst_xm", 128'({o_i, o_bytes, o_key}), 128'(0));
        check("rst_out", o_out, 128'(0));
        reset = 1'b1;
        @(negedge clk);
        check("rel_sr", 128'(o_sr), 128'(1'b1));

        // FIPS-197 initial round, then backpressure, then random jobs with intrusion.
        run_job(FIPS_S, FIPS_K, 1, 0, 1'b0);
        check("fips_r1", o_out, FIPS_R);
        run_job(rnd128(), rnd128(), 1, 10, 1'b0);
        for (int j = 0; j < 4; j++) run_job(rnd128(), rnd128(), 1, j, 1'b1);

        // Back-to-back with start_valid and result_ready held high.
        s = rnd128();
        state_in = s; key_in = '0; start_valid = 1'b1; result_ready = 1'b1;
        @(negedge clk);
        check("b2b_i0", 128'(o_i), 128'(0));
        key_in = '1;
        repeat (4) @(negedge clk);
        check("b2b_rv0", 128'(o_rv), 128'(1'b0));
        @(negedge clk);
        check("b2b_rv1", 128'(o_rv), 128'(1'b1));
        check("b2b_res1", o_out, s);
        @(negedge clk);
        check("b2b_gap", 128'({o_rv, o_sr, o_busy}), 128'(3'b010));
        @(negedge clk);
        start_valid = 1'b0;
        check("b2b_acc2", 128'({o_busy, o_i}), 128'({1'b1, 3'd0}));
        check("b2b_key2", 128'(o_key), 128'(32'hffffffff));
        repeat (4) @(negedge clk);
        check("b2b_rv2_0", 128'(o_rv), 128'(1'b0));
        @(negedge clk);
        check("b2b_rv2_1", 128'(o_rv), 128'(1'b1));
        check("b2b_res2", o_out, ~s);
        @(negedge clk);
        result_ready = 1'b0;
        check("b2b_end", 128'({o_rv, o_sr}), 128'(2'b01));

        // Asynchronous reset during ISSUE column 2.
        state_in = rnd128(); key_in = rnd128(); start_valid = 1'b1;
        repeat (3) @(negedge clk);
        start_valid = 1'b0;
        check("mid_i2", 128'(o_i), 128'(2));
        #2 reset = 1'b0;
        #1;
        check("mid_rst_flags", 128'({o_sr, o_rv, o_busy}), 128'(3'b000));
        check("mid_rst_xm", 128'({o_i, o_bytes, o_key}), 128'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_job(rnd128(), rnd128(), 1, 2, 1'b0);

        // COL_LAT = 3 build on the FIPS vector.
        sel = 1'b1;
        @(negedge clk);
        run_job(FIPS_S, FIPS_K, 3, 1, 1'b0);
        check("fips_r3", o_out, FIPS_R);
        run_job(rnd128(), rnd128(), 3, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
